// File: rtl/subtree_rr_scheduler.sv
// Round-robin scheduler sharing one downstream command channel among NUM_REQ
// leaf requesters; holds the grant until done or a forced timeout release.
module subtree_rr_scheduler #(
   parameter int NUM_REQ = 5,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic                        done,
   input  logic                        out_ready,
   output logic [NUM_REQ-1:0]          gnt,
   output logic                        out_valid,
   output logic [DATA_W-1:0]           out_data,
   output logic [2:0]                  out_id,
   output logic                        busy,
   output logic                        timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_BUSY    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic                 out_valid_q, out_valid_d;
   logic [DATA_W-1:0]    out_data_q, out_data_d;
   logic [2:0]           out_id_q, out_id_d;
   logic                 busy_q, busy_d;
   logic                 timeout_err_q, timeout_err_d;
   logic [2:0]           ptr_q, ptr_d;
   logic [7:0]           cnt_q, cnt_d;

   logic                 found_s;
   logic [2:0]           pick_s;
   logic [3:0]           cand_s;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [2:0] idx);
      logic [NUM_REQ-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [2:0] next_ptr(input logic [2:0] id);
      logic [2:0] n;
      if (id == 3'(NUM_REQ - 1)) begin
         n = 3'd0;
      end else begin
         n = id + 3'd1;
      end
      return n;
   endfunction

   // Next-state and output computation, including the rotating priority search.
   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_id_d      = out_id_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      timeout_err_d = 1'b0;
      found_s       = 1'b0;
      pick_s        = 3'd0;
      cand_s        = 4'd0;

      // Search ptr, ptr+1, ... wrapping at NUM_REQ; first hit wins.
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_s = {1'b0, ptr_q} + 4'(k);
         if (cand_s >= 4'(NUM_REQ)) begin
            cand_s = cand_s - 4'(NUM_REQ);
         end else begin
            cand_s = cand_s;
         end
         if (!found_s && req[cand_s[2:0]]) begin
            found_s = 1'b1;
            pick_s  = cand_s[2:0];
         end else begin
            found_s = found_s;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (found_s) begin
               state_d     = S_ISSUE;
               gnt_d       = onehot(pick_s);
               out_id_d    = pick_s;
               out_data_d  = req_data[int'(pick_s)*DATA_W +: DATA_W];
               out_valid_d = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               cnt_d       = 8'd0;
               state_d     = S_BUSY;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_BUSY: begin
            // done takes priority over a coincident timeout.
            if (done) begin
               state_d = S_RELEASE;
               gnt_d   = '0;
               ptr_d   = next_ptr(out_id_q);
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               state_d       = S_RELEASE;
               gnt_d         = '0;
               ptr_d         = next_ptr(out_id_q);
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RELEASE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d     = S_IDLE;
            gnt_d       = '0;
            out_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         gnt_q         <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_id_q      <= 3'd0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         ptr_q         <= 3'd0;
         cnt_q         <= 8'd0;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_id_q      <= out_id_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
      end
   end

   assign gnt         = gnt_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_id      = out_id_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

endmodule
